mem_stage_mc: RTL and testbench

Pipelined memory-access (MEM) stage for the pipelined MIPS core. It replaces the fixed single-cycle data-memory path with a parametrised, variable-latency request/acknowledge port, which lets the data memory be an SRAM with wait states or a cache. It owns the MEM→WB pipeline register, produces its own stall request toward the hazard unit, and handles sub-word lane steering, extension and misalignment detection.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_stage_mc.sv | 149 ++++++++++++++
 tb/tb_mem_stage_mc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: pipeline control codes, access sizes,
// the bubble instruction and the request FSM states.
package mem_pkg;

    localparam logic [1:0] COND_FLOW  = 2'b00;
    localparam logic [1:0] COND_STALL = 2'b01;
    localparam logic [1:0] COND_ZERO  = 2'b10;
    localparam logic [1:0] COND_HOLD  = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [31:0] IR_NON = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// plus load data shift-down and sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic [LANE_W-1:0]   i_lane,
    input  logic [1:0]          i_size,
    input  logic                i_sext,
    input  logic [DATA_W-1:0]   i_rt,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic [DATA_W/8-1:0] o_be,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W-1:0]   o_ldata
);

    localparam int NB = DATA_W/8;

    logic [NB-1:0]     w_mask;
    logic [DATA_W-1:0] w_shift;
    logic              w_sign;

    always_comb begin
        w_mask  = '0;
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < (1 << i_size));
            // Replicate the low size-bytes of rt across every lane
            case (i_size)
                SZ_BYTE: o_wdata[i*8 +: 8] = i_rt[7:0];
                SZ_HALF: o_wdata[i*8 +: 8] = i_rt[(i%2)*8 +: 8];
                SZ_WORD: o_wdata[i*8 +: 8] = i_rt[(i%4)*8 +: 8];
                default: o_wdata[i*8 +: 8] = i_rt[i*8 +: 8];
            endcase
        end
        o_be = w_mask << i_lane;
    end

    always_comb begin
        w_shift = i_rdata >> {i_lane, 3'b000};
        case (i_size)
            SZ_BYTE: w_sign = w_shift[7];
            SZ_HALF: w_sign = w_shift[15];
            SZ_WORD: w_sign = w_shift[31];
            default: w_sign = w_shift[DATA_W-1];
        endcase
        w_sign  = w_sign & i_sext;
        o_ldata = '0;
        for (int j = 0; j < DATA_W; j++)
            o_ldata[j] = (j < (8 << i_size)) ? w_shift[j] : w_sign;
    end

endmodule

// File: rtl/mem_stage_mc.sv
// MIPS MEM stage with a variable-latency req/ack data-memory port, its own
// stall request, and the MEM->WB pipeline register.
module mem_stage_mc
    import mem_pkg::*;
#(
    parameter int               DATA_W    = 32,
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] DMEM_BASE = 32'h1001_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cond,
    input  logic [31:0]         ex_ir,
    input  logic [ADDR_W-1:0]   ex_z,
    input  logic [DATA_W-1:0]   ex_rt,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_sext,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W/8-1:0] dm_be,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_busy,
    output logic                mis_align,
    output logic [31:0]         wb_ir,
    output logic [ADDR_W-1:0]   wb_z,
    output logic [DATA_W-1:0]   wb_mem,
    output logic [DATA_W-1:0]   wb_hi,
    output logic [DATA_W-1:0]   wb_lo,
    output logic                wb_valid
);

    localparam int LANE_W = $clog2(DATA_W/8);

    mem_state_e        r_state, w_next;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_ldata;
    logic              w_mis, w_access, w_load, w_req, w_busy;

    mem_lane_align #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_align (
        .i_lane  (ex_z[LANE_W-1:0]),
        .i_size  (mem_size),
        .i_sext  (mem_sext),
        .i_rt    (ex_rt),
        .i_rdata (dm_rdata),
        .o_be    (dm_be),
        .o_wdata (dm_wdata),
        .o_ldata (w_ldata)
    );

    // Double-word accesses only exist on a 64-bit datapath
    always_comb begin
        case (mem_size)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = ex_z[0];
            SZ_WORD: w_mis = |ex_z[1:0];
            default: w_mis = (DATA_W == 32) ? 1'b1 : |ex_z[2:0];
        endcase
    end

    assign mis_align = (mem_rd | mem_wr) & w_mis;
    assign w_access  = (mem_rd | mem_wr) & ~mis_align &
                       (cond != COND_ZERO) & (cond != COND_HOLD);
    assign w_load    = mem_rd & ~mem_wr & ~mis_align;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_req  = 1'b1;
                    w_busy = 1'b1;
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                // A flush still has to finish the handshake before returning to IDLE
                if (cond == COND_ZERO) w_next = dm_ack ? ST_IDLE : ST_DRAIN;
                else if (dm_ack)       w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_DRAIN: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                if (dm_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (rst) begin
            w_req  = 1'b0;
            w_busy = 1'b0;
        end
    end

    assign dm_req   = w_req;
    assign dm_we    = w_req & mem_wr;
    assign dm_addr  = ex_z - DMEM_BASE;
    assign mem_busy = w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (r_state == ST_WAIT && dm_ack && cond != COND_ZERO)
            r_rdata <= w_ldata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!rst && cond == COND_ZERO)) begin
            wb_ir    <= IR_NON;
            wb_z     <= '0;
            wb_mem   <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_valid <= 1'b0;
        end else if (cond == COND_STALL || cond == COND_HOLD) begin
            wb_valid <= wb_valid;
        end else if (w_busy) begin
            wb_ir    <= IR_NON;
            wb_z     <= '0;
            wb_mem   <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_valid <= 1'b0;
        end else begin
            wb_ir    <= ex_ir;
            wb_z     <= ex_z;
            wb_mem   <= w_load ? r_rdata : '0;
            wb_hi    <= ex_hi;
            wb_lo    <= ex_lo;
            wb_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: loads, stores, wait states, misalignment,
// flush during a request and reset during a request.
module tb_mem_stage_mc;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cond;
    logic [31:0] ex_ir, ex_z, ex_rt, ex_hi, ex_lo;
    logic        mem_rd, mem_wr, mem_sext;
    logic [1:0]  mem_size;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_busy, mis_align, wb_valid;
    logic [31:0] wb_ir, wb_z, wb_mem, wb_hi, wb_lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_stage_mc dut (
        .clk(clk), .rst(rst), .cond(cond), .ex_ir(ex_ir), .ex_z(ex_z),
        .ex_rt(ex_rt), .ex_hi(ex_hi), .ex_lo(ex_lo), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_size(mem_size), .mem_sext(mem_sext),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_busy(mem_busy), .mis_align(mis_align), .wb_ir(wb_ir),
        .wb_z(wb_z), .wb_mem(wb_mem), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_valid(wb_valid)
    );

    task automatic drive_op(input logic [31:0] ir, input logic [31:0] z,
                            input logic [31:0] rt, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sx, input logic [1:0] c);
        ex_ir = ir; ex_z = z; ex_rt = rt;
        ex_hi = ir ^ 32'h5555_0000; ex_lo = ~ir;
        mem_rd = rd; mem_wr = wr; mem_size = sz; mem_sext = sx; cond = c;
    endtask

    // Issue one op with cond=FLOW, ack it ack_cyc cycles after the request
    // cycle, and return after the edge on which WB captures it.
    task automatic run_access(input logic [31:0] ir, input logic [31:0] z,
                              input logic [31:0] rt, input logic [31:0] rdata,
                              input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sx, input int ack_cyc,
                              output int busy_n, output int vld_n, output bit req_seen,
                              output bit done_ok, output logic [3:0] be0,
                              output logic [31:0] wd0, output logic we0,
                              output logic [31:0] addr0, output logic mis0);
        drive_op(ir, z, rt, rd, wr, sz, sx, COND_FLOW);
        dm_rdata = rdata;
        busy_n = 0; vld_n = 0; req_seen = 0; done_ok = 0;
        be0 = '0; wd0 = '0; we0 = 0; addr0 = '0; mis0 = 0;
        for (int c = 0; c < 64; c++) begin
            dm_ack = (c == ack_cyc);
            #1;
            if (c == 0) begin
                be0 = dm_be; wd0 = dm_wdata; we0 = dm_we; addr0 = dm_addr; mis0 = mis_align;
            end
            if (dm_req) req_seen = 1;
            if (!mem_busy) begin
                done_ok = 1;
                break;
            end
            busy_n++;
            if (c > 0 && wb_valid) vld_n++;
            @(posedge clk); #1;
        end
        dm_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        drive_op(32'h0000_0820, 32'h0, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        @(posedge clk); #1;
        n_total++; if (wb_ir !== IR_NON) $display("FAIL reset_wb_ir got %h want %h", wb_ir, IR_NON); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else n_pass++;
        n_total++; if (wb_mem !== 32'h0) $display("FAIL reset_wb_mem got %h want 0", wb_mem); else n_pass++;
        n_total++; if (dm_req !== 1'b0) $display("FAIL reset_dm_req got %b want 0", dm_req); else n_pass++;
        n_total++; if (mem_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", mem_busy); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        int b, v; bit rq, ok; logic [3:0] be; logic [31:0] wd, ad; logic we, mis;
        run_access(32'h8C08_0004, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1, 0, SZ_WORD, 0, 1,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (ad !== 32'h4) $display("FAIL lw_addr got %h want 00000004", ad); else n_pass++;
        n_total++; if (be !== 4'b1111) $display("FAIL lw_be got %b want 1111", be); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL lw_we got %b want 0", we); else n_pass++;
        n_total++; if (b != 2 || !ok) $display("FAIL lw_busy_cycles got %0d (done %0d) want 2", b, ok); else n_pass++;
        n_total++; if (wb_mem !== 32'hDEAD_BEEF) $display("FAIL lw_wb_mem got %h want deadbeef", wb_mem); else n_pass++;
        n_total++; if (wb_valid !== 1'b1) $display("FAIL lw_wb_valid got %b want 1", wb_valid); else n_pass++;
        n_total++; if (wb_ir !== 32'h8C08_0004) $display("FAIL lw_wb_ir got %h want 8c080004", wb_ir); else n_pass++;
        n_total++; if (wb_z !== 32'h1001_0004) $display("FAIL lw_wb_z got %h want 10010004", wb_z); else n_pass++;
        n_total++; if (wb_hi !== 32'hD95D_0004) $display("FAIL lw_wb_hi got %h want d95d0004", wb_hi); else n_pass++;
    endtask

    task automatic test_lb;
        int b, v; bit rq, ok; logic [3:0] be; logic [31:0] wd, ad; logic we, mis;
        run_access(32'h8008_0003, 32'h1001_0003, 32'h0, 32'h80FF_FFFF, 1, 0, SZ_BYTE, 1, 1,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (be !== 4'b1000) $display("FAIL lb_be got %b want 1000", be); else n_pass++;
        n_total++; if (wb_mem !== 32'hFFFF_FF80) $display("FAIL lb_sext got %h want ffffff80", wb_mem); else n_pass++;
        run_access(32'h9008_0003, 32'h1001_0003, 32'h0, 32'h80FF_FFFF, 1, 0, SZ_BYTE, 0, 1,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (wb_mem !== 32'h0000_0080) $display("FAIL lbu_zext got %h want 00000080", wb_mem); else n_pass++;
    endtask

    task automatic test_sh;
        int b, v; bit rq, ok; logic [3:0] be; logic [31:0] wd, ad; logic we, mis;
        run_access(32'hA408_0002, 32'h1001_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1, SZ_HALF, 0, 1,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (be !== 4'b1100) $display("FAIL sh_be got %b want 1100", be); else n_pass++;
        n_total++; if (wd !== 32'hABCD_ABCD) $display("FAIL sh_wdata got %h want abcdabcd", wd); else n_pass++;
        n_total++; if (we !== 1'b1) $display("FAIL sh_we got %b want 1", we); else n_pass++;
        n_total++; if (ad !== 32'h2) $display("FAIL sh_addr got %h want 00000002", ad); else n_pass++;
        n_total++; if (wb_mem !== 32'h0) $display("FAIL sh_wb_mem got %h want 0", wb_mem); else n_pass++;
        n_total++; if (wb_valid !== 1'b1 || b != 2) $display("FAIL sh_flow got valid %b busy %0d want 1/2", wb_valid, b); else n_pass++;
    endtask

    task automatic test_wait_states;
        int b, v; bit rq, ok; logic [3:0] be; logic [31:0] wd, ad; logic we, mis;
        // ack arrives three cycles after the request cycle
        run_access(32'h8C0A_0008, 32'h1001_0008, 32'h0, 32'h0BAD_F00D, 1, 0, SZ_WORD, 0, 3,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (b != 4 || !ok) $display("FAIL ws_busy_cycles got %0d (done %0d) want 4", b, ok); else n_pass++;
        n_total++; if (v != 0) $display("FAIL ws_valid_while_busy got %0d want 0", v); else n_pass++;
        n_total++; if (wb_mem !== 32'h0BAD_F00D) $display("FAIL ws_wb_mem got %h want 0badf00d", wb_mem); else n_pass++;
        n_total++; if (wb_valid !== 1'b1) $display("FAIL ws_wb_valid got %b want 1", wb_valid); else n_pass++;
    endtask

    task automatic test_misalign;
        int b, v; bit rq, ok; logic [3:0] be; logic [31:0] wd, ad; logic we, mis;
        run_access(32'h8408_0001, 32'h1001_0001, 32'h0, 32'hFFFF_FFFF, 1, 0, SZ_HALF, 1, 1,
                   b, v, rq, ok, be, wd, we, ad, mis);
        n_total++; if (mis !== 1'b1) $display("FAIL mis_flag got %b want 1", mis); else n_pass++;
        n_total++; if (rq || b != 0) $display("FAIL mis_no_req got req %0d busy %0d want 0/0", rq, b); else n_pass++;
        n_total++; if (wb_mem !== 32'h0) $display("FAIL mis_wb_mem got %h want 0", wb_mem); else n_pass++;
        n_total++; if (wb_valid !== 1'b1 || wb_ir !== 32'h8408_0001)
            $display("FAIL mis_flow got valid %b ir %h want 1/84080001", wb_valid, wb_ir); else n_pass++;
    endtask

    task automatic test_drain;
        drive_op(32'h8C09_0010, 32'h1001_0010, 32'h0, 1, 0, SZ_WORD, 0, COND_FLOW);
        dm_ack = 1'b0; dm_rdata = 32'h1111_2222;
        #1;
        n_total++; if (dm_req !== 1'b1) $display("FAIL drain_issue_req got %b want 1", dm_req); else n_pass++;
        @(posedge clk); #1;
        cond = COND_ZERO;
        @(posedge clk); #1;
        cond = COND_STALL;
        #1;
        n_total++; if (dm_req !== 1'b1 || mem_busy !== 1'b1)
            $display("FAIL drain_req got req %b busy %b want 1/1", dm_req, mem_busy); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL drain_wb_valid1 got %b want 0", wb_valid); else n_pass++;
        @(posedge clk); #1;
        dm_ack = 1'b1;
        #1;
        n_total++; if (dm_req !== 1'b1) $display("FAIL drain_req_at_ack got %b want 1", dm_req); else n_pass++;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        drive_op(32'h0000_0020, 32'h0000_0077, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        #1;
        n_total++; if (mem_busy !== 1'b0 || dm_req !== 1'b0)
            $display("FAIL drain_idle got busy %b req %b want 0/0", mem_busy, dm_req); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL drain_wb_valid2 got %b want 0", wb_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wb_valid !== 1'b1 || wb_ir !== 32'h0000_0020 || wb_z !== 32'h77)
            $display("FAIL drain_next_flow got valid %b ir %h z %h want 1/00000020/00000077", wb_valid, wb_ir, wb_z); else n_pass++;
    endtask

    task automatic test_reset_wait;
        drive_op(32'h0000_0821, 32'h5, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        dm_ack = 1'b0;
        @(posedge clk); #1;
        drive_op(32'h8C0B_0000, 32'h1001_0000, 32'h0, 1, 0, SZ_WORD, 0, COND_STALL);
        @(posedge clk); #1;
        n_total++; if (dm_req !== 1'b1 || wb_valid !== 1'b1 || wb_ir !== 32'h0000_0821)
            $display("FAIL rstw_pre got req %b valid %b ir %h want 1/1/00000821", dm_req, wb_valid, wb_ir); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (dm_req !== 1'b0 || mem_busy !== 1'b0)
            $display("FAIL rstw_req got req %b busy %b want 0/0", dm_req, mem_busy); else n_pass++;
        n_total++; if (wb_ir !== IR_NON || wb_valid !== 1'b0)
            $display("FAIL rstw_wb got ir %h valid %b want %h/0", wb_ir, wb_valid, IR_NON); else n_pass++;
        #1;
        rst = 1'b0;
        drive_op(32'h0000_0822, 32'h6, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        @(posedge clk); #1;
        n_total++; if (wb_ir !== 32'h0000_0822 || wb_valid !== 1'b1)
            $display("FAIL rstw_after got ir %h valid %b want 00000822/1", wb_ir, wb_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        // A stray ack outside WAIT/DRAIN must not disturb non-memory flow
        dm_ack = 1'b1;
        drive_op(32'h0123_0020, 32'hA, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        #1;
        n_total++; if (mem_busy !== 1'b0 || dm_req !== 1'b0)
            $display("FAIL b2b_idle got busy %b req %b want 0/0", mem_busy, dm_req); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wb_ir !== 32'h0123_0020 || wb_z !== 32'hA)
            $display("FAIL b2b_first got ir %h z %h want 01230020/0000000a", wb_ir, wb_z); else n_pass++;
        drive_op(32'h0456_0022, 32'hB, 32'h0, 0, 0, SZ_WORD, 0, COND_FLOW);
        @(posedge clk); #1;
        n_total++; if (wb_ir !== 32'h0456_0022 || wb_lo !== 32'hFBA9_FFDD)
            $display("FAIL b2b_second got ir %h lo %h want 04560022/fba9ffdd", wb_ir, wb_lo); else n_pass++;
        drive_op(32'h0789_0024, 32'hC, 32'h0, 0, 0, SZ_WORD, 0, COND_HOLD);
        @(posedge clk); #1;
        n_total++; if (wb_ir !== 32'h0456_0022) $display("FAIL b2b_hold got ir %h want 04560022", wb_ir); else n_pass++;
        dm_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_wait_states();
        test_misalign();
        test_drain();
        test_reset_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
